// File: rtl/seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan
//  Purpose  : Time-multiplexed digit scanner for a multi-digit seven-segment
//             display. Double-buffers a packed BCD word and takes new values
//             only at frame boundaries. Visits one digit position per slot.
//             Each slot has a programmable dwell time, an anti-ghosting blank
//             gap, and optional leading-zero blanking.
//  Ports    : clk         - system clock
//             rst_n       - asynchronous active-low reset
//             en_i        - scan enable (low forces IDLE)
//             load_i      - strobe, captures data_i into the shadow buffer
//             data_i      - packed BCD word, nibble k is digit k
//             data_o      - digit value for seg_decode (4'hF = blank)
//             sel_o       - one-hot digit select, polarity per SEL_INVERSE
//             frame_o     - one-cycle pulse at the start of every frame
//             load_done_o - one-cycle pulse when shadow is copied to active
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan #(
   parameter int DIGITS       = 4,
   parameter int SCAN_DIV     = 50000,
   parameter int BLANK_CYCLES = 500,
   parameter bit SEL_INVERSE  = 1'b1,
   parameter bit LZ_BLANK     = 1'b0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   data_i,
   output logic [3:0]            data_o,
   output logic [DIGITS-1:0]     sel_o,
   output logic                  frame_o,
   output logic                  load_done_o
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0]  C_SHOW_LAST = CNT_W'(SCAN_DIV - BLANK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  C_SLOT_LAST = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  C_IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [DIGITS-1:0] C_SEL_OFF   = {DIGITS{SEL_INVERSE}};
   localparam bit                C_HAS_BLANK = (BLANK_CYCLES > 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHOW  = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [4*DIGITS-1:0]   active_q, active_d;
   logic                  pend_q, pend_d;
   logic                  bnd_q, bnd_d;       // frame boundary taken on the last edge
   logic                  ldevt_q, ldevt_d;   // shadow->active copy taken on the last edge
   logic [3:0]            data_q, data_d;
   logic [DIGITS-1:0]     sel_q, sel_d;
   logic                  frame_q, load_done_q;

   logic                  slot_end;
   logic [DIGITS-1:0]     sel_raw;
   logic                  zero_run;

   // ------------------------------------------------------------------------
   // Scan FSM: next state, slot counter and digit index
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      bnd_d    = 1'b0;
      slot_end = 1'b0;

      if (!en_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_SHOW;
               cnt_d   = '0;
               idx_d   = '0;
               bnd_d   = 1'b1;
            end
            ST_SHOW: begin
               cnt_d = cnt_q + 1'b1;
               if (C_HAS_BLANK && (cnt_q == C_SHOW_LAST)) begin
                  state_d = ST_BLANK;
               end else if (!C_HAS_BLANK && (cnt_q == C_SLOT_LAST)) begin
                  slot_end = 1'b1;
               end
            end
            ST_BLANK: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == C_SLOT_LAST) begin
                  state_d  = ST_SHOW;
                  slot_end = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase

         // Wrapping from the last digit back to digit 0 starts a new frame.
         if (slot_end) begin
            cnt_d = '0;
            if (idx_q == C_IDX_LAST) begin
               idx_d = '0;
               bnd_d = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Double buffer. The copy uses the shadow value from before the edge; a
   // load in the same cycle refills shadow and re-arms pending (set wins).
   // ------------------------------------------------------------------------
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      pend_d   = pend_q;
      ldevt_d  = 1'b0;

      if (bnd_d && pend_q) begin
         active_d = shadow_q;
         pend_d   = 1'b0;
         ldevt_d  = 1'b1;
      end
      if (load_i) begin
         shadow_d = data_i;
         pend_d   = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output decode from the current state. Outputs are blanked as soon as
   // en_i drops so the display goes dark on the very next edge. zero_run
   // accumulates "this digit and all higher digits are zero" from the top.
   // ------------------------------------------------------------------------
   always_comb begin
      sel_raw  = '0;
      data_d   = 4'hF;
      zero_run = 1'b1;

      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_run = zero_run && (active_q[4*k +: 4] == 4'h0);
         if (en_i && (state_q == ST_SHOW) && (idx_q == IDX_W'(k))) begin
            sel_raw[k] = 1'b1;
            if (LZ_BLANK && (k != 0) && zero_run) begin
               data_d = 4'hF;
            end else begin
               data_d = active_q[4*k +: 4];
            end
         end
      end

      sel_d = sel_raw ^ C_SEL_OFF;
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shadow_q    <= '0;
         active_q    <= '0;
         pend_q      <= 1'b0;
         bnd_q       <= 1'b0;
         ldevt_q     <= 1'b0;
         data_q      <= 4'hF;
         sel_q       <= C_SEL_OFF;
         frame_q     <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         active_q    <= active_d;
         pend_q      <= pend_d;
         bnd_q       <= bnd_d;
         ldevt_q     <= ldevt_d;
         data_q      <= data_d;
         sel_q       <= sel_d;
         // Delayed one edge so the pulses line up with the first cycle of
         // digit 0 appearing on sel_o/data_o.
         frame_q     <= bnd_q;
         load_done_q <= ldevt_q;
      end
   end

   assign data_o      = data_q;
   assign sel_o       = sel_q;
   assign frame_o     = frame_q;
   assign load_done_o = load_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan
//  Purpose  : Self-checking bench for seg_scan. Two instances share stimulus:
//             one without and one with leading-zero blanking. The stimulus
//             pushes the expected frame word and load-done flag at every
//             frame boundary. A negedge monitor pops them on frame_o and
//             checks each cycle of the frame.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan;

   localparam int ND    = 4;
   localparam int SD    = 4;
   localparam int BL    = 1;
   localparam int FRAME = ND * SD;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en_i;
   logic          load_i;
   logic [15:0]   data_i;
   logic [3:0]    data_o, data_lz;
   logic [3:0]    sel_o, sel_lz;
   logic          frame_o, frame_lz;
   logic          load_done_o, load_done_lz;

   always #5 clk = ~clk;

   seg_scan #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BL),
              .SEL_INVERSE(1'b1), .LZ_BLANK(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .load_i(load_i), .data_i(data_i),
      .data_o(data_o), .sel_o(sel_o), .frame_o(frame_o), .load_done_o(load_done_o));

   seg_scan #(.DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BL),
              .SEL_INVERSE(1'b1), .LZ_BLANK(1'b1)) dut_lz (
      .clk(clk), .rst_n(rst_n), .en_i(en_i), .load_i(load_i), .data_i(data_i),
      .data_o(data_lz), .sel_o(sel_lz), .frame_o(frame_lz), .load_done_o(load_done_lz));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model / scoreboard queue --------------------
   typedef struct {
      int word;
      bit ld;
   } exp_t;

   exp_t exp_q[$];
   bit   mon_on = 1'b0;

   bit   m_run    = 1'b0;
   int   m_phase  = 0;
   int   m_shadow = 0;
   int   m_active = 0;
   bit   m_pend   = 1'b0;

   // One clock edge seen at frame level: frames start when enable is first
   // seen and then every FRAME edges; loads before a boundary are shown in it.
   task automatic model_edge(input bit en, input bit ld, input int d);
      bit   bnd;
      exp_t e;
      bnd = 1'b0;
      if (en) begin
         if (!m_run) begin
            m_run   = 1'b1;
            m_phase = 0;
            bnd     = 1'b1;
         end else begin
            m_phase = (m_phase + 1) % FRAME;
            bnd     = (m_phase == 0);
         end
         if (bnd) begin
            e.ld = m_pend;
            if (m_pend) m_active = m_shadow;
            m_pend = 1'b0;
            e.word = m_active;
            exp_q.push_back(e);
         end
      end else begin
         m_run = 1'b0;
      end
      if (ld) begin
         m_shadow = d;
         m_pend   = 1'b1;
      end
   endtask

   task automatic cyc(input bit en, input bit ld, input int d);
      en_i   = en;
      load_i = ld;
      if (ld) data_i = d[15:0];
      model_edge(en, ld, d);
      @(posedge clk);
      #1;
      load_i = 1'b0;
   endtask

   task automatic run_frames(input int n);
      for (int i = 0; i < n * FRAME; i++) cyc(1'b1, 1'b0, 0);
   endtask

   // Advance until the next edge will land on the given frame phase.
   task automatic wait_before(input int target);
      int n;
      n = 0;
      while (((m_phase + 1) % FRAME != target) && n < 2 * FRAME) begin
         cyc(1'b1, 1'b0, 0);
         n++;
      end
   endtask

   // ---------------- monitor ------------------------------------------------
   int   pos = -1;
   int   gap = 0;
   bit   gap_ok = 1'b0;
   int   cur = 0;

   always @(negedge clk) begin
      exp_t e;
      int   slot, off, esel, enib, elz;
      if (!rst_n || !mon_on) begin
         pos    = -1;
         gap_ok = 1'b0;
      end else begin
         if (frame_o) begin
            if (gap_ok) check("frame_period", gap, FRAME);
            gap    = 0;
            gap_ok = 1'b1;
            if (exp_q.size() == 0) begin
               check("frame_unexpected", 1, 0);
               pos = -1;
            end else begin
               e   = exp_q.pop_front();
               cur = e.word;
               check("load_done", load_done_o, e.ld);
               check("lz_frame", frame_lz, 1);
               pos = 0;
            end
         end
         if (pos >= 0) begin
            slot = pos / SD;
            off  = pos % SD;
            if (off < SD - BL) begin
               esel = (~(1 << slot)) & 'hF;
               enib = (cur >> (4 * slot)) & 'hF;
               elz  = (slot > 0 && (cur >> (4 * slot)) == 0) ? 'hF : enib;
            end else begin
               esel = 'hF;
               enib = 'hF;
               elz  = 'hF;
            end
            check("sel", sel_o, esel);
            check("data", data_o, enib);
            check("sel_lz", sel_lz, esel);
            check("data_lz", data_lz, elz);
            if (pos > 0) check("load_done_idle", load_done_o, 0);
            pos++;
            if (pos == FRAME) pos = -1;
         end
         gap++;
      end
   end

   // ---------------- stimulus ----------------------------------------------
   initial begin
      rst_n  = 1'b0;
      en_i   = 1'b0;
      load_i = 1'b0;
      data_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sel", sel_o, 4'hF);
      check("rst_data", data_o, 4'hF);
      check("rst_frame", frame_o, 0);
      check("rst_load_done", load_done_o, 0);
      check("rst_sel_lz", sel_lz, 4'hF);
      check("rst_data_lz", data_lz, 4'hF);
      rst_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 1'b0, 0);
         check("idle_sel", sel_o, 4'hF);
         check("idle_data", data_o, 4'hF);
         check("idle_frame", frame_o, 0);
      end

      // Scan order
      cyc(1'b0, 1'b1, 16'h4321);
      cyc(1'b0, 1'b0, 0);
      mon_on = 1'b1;
      run_frames(2);

      // Tear-free load during digit 2
      wait_before(2 * SD + 1);
      cyc(1'b1, 1'b1, 16'h8765);
      run_frames(2);

      // Load coinciding with the frame boundary while another is pending
      wait_before(6);
      cyc(1'b1, 1'b1, 16'h2222);
      wait_before(0);
      cyc(1'b1, 1'b1, 16'h1111);
      run_frames(3);

      // Randomized loads of varying significance, nibbles above 9 included
      for (int i = 0; i < 400; i++) begin
         int w;
         w = $urandom & ((1 << (4 * $urandom_range(1, 4))) - 1);
         cyc(1'b1, ($urandom_range(0, 5) == 0), w);
      end

      // Disable during digit 2; shadow loaded while idle must survive
      wait_before(2 * SD + 1);
      check("queue_drained", exp_q.size(), 0);
      mon_on = 1'b0;
      exp_q.delete();
      cyc(1'b0, 1'b0, 0);
      check("dis_sel", sel_o, 4'hF);
      check("dis_data", data_o, 4'hF);
      check("dis_sel_lz", sel_lz, 4'hF);
      cyc(1'b0, 1'b1, 16'h0050);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 0);
         check("dis_frame", frame_o, 0);
         check("dis_sel2", sel_o, 4'hF);
      end
      mon_on = 1'b1;
      run_frames(2);

      // Asynchronous reset in the middle of a slot
      wait_before(6);
      #2;
      mon_on = 1'b0;
      rst_n  = 1'b0;
      en_i   = 1'b0;
      #1;
      check("arst_sel", sel_o, 4'hF);
      check("arst_data", data_o, 4'hF);
      check("arst_frame", frame_o, 0);
      check("arst_sel_lz", sel_lz, 4'hF);
      exp_q.delete();
      m_run    = 1'b0;
      m_shadow = 0;
      m_active = 0;
      m_pend   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 0);
      mon_on = 1'b1;
      run_frames(2);

      wait_before(6);
      check("queue_final", exp_q.size(), 0);
      mon_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
# seg_scan

Time-multiplexed digit scanner for the multi-digit seven-segment display. It holds a packed BCD display word in a double buffer, steps one digit position at a time, and drives the 4-bit digit value into `seg_decode` together with the matching digit-select line. It provides a programmable dwell time, an anti-ghosting blank gap and optional leading-zero blanking. New values are taken only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
- `DIGITS`, 4: number of digit positions, 1..8.
- `SCAN_DIV`, 50000: clock cycles per digit slot, ≥2.
- `BLANK_CYCLES`, 500: cycles at the end of each slot with all selects inactive, 0..SCAN_DIV-1.
- `SEL_INVERSE`, 1'b1: 1 = digit selects active-low, 0 = active-high.
- `LZ_BLANK`, 1'b0: 1 = suppress leading zeros.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  scan enable.
- `load_i`  in  1  single-cycle strobe; captures `data_i` into the shadow buffer.
- `data_i`  in  4*DIGITS  packed BCD word; nibble k (`data_i[4k+3:4k]`) is digit k; digit 0 is least significant.
- `data_o`  out  4  digit value to `seg_decode`; 4'hF = blank, which decodes to all segments off.
- `sel_o`  out  DIGITS  one-hot digit select; polarity set by SEL_INVERSE.
- `frame_o`  out  1  one-cycle pulse at the start of each frame (digit 0 slot).
- `load_done_o`  out  1  one-cycle pulse when the shadow buffer is copied to the active buffer.

## Operation
- Storage:
  - shadow[4*DIGITS], active[4*DIGITS], `pending` flag.
  - Slot counter `cnt` of width $clog2(SCAN_DIV); digit index `idx` of width $clog2(DIGITS), minimum 1 bit.
- `load_i`=1: shadow <= `data_i`, pending <= 1. The last strobe before a frame boundary wins.
- Frame boundary: any entry to slot `idx`=0, either from IDLE or by wrapping from DIGITS-1.
  - If pending was set before the edge: active <= shadow (value before the edge), pending <= 0, `load_done_o` pulses.
  - If `load_i` is high in the same cycle, the new data goes to shadow and pending stays 1 (set wins over clear).
- FSM states IDLE, SHOW, BLANK:
  - IDLE: selects inactive, `data_o`=4'hF. `en_i`=1 → SHOW with `idx`=0, `cnt`=0, frame boundary.
  - SHOW: `sel_o` bit `idx` active, `data_o` = digit value (see blanking rule). `cnt` increments each cycle.
    - At `cnt`=SCAN_DIV-BLANK_CYCLES-1 with BLANK_CYCLES>0 → BLANK.
    - At `cnt`=SCAN_DIV-1 with BLANK_CYCLES=0 → next slot.
  - BLANK: selects inactive, `data_o`=4'hF, `cnt` keeps incrementing. At `cnt`=SCAN_DIV-1 → SHOW, next slot.
  - Next slot: `cnt`<=0, `idx`<=idx+1. From DIGITS-1 it wraps to 0, which is a frame boundary.
  - `en_i`=0 in any state → IDLE on the next edge; `idx`, `cnt` cleared; shadow and pending kept.
- Leading-zero blanking (LZ_BLANK=1): digit k (k≥1) shows 4'hF when it and every higher digit of active are 0. Digit 0 is always shown.
- Active nibbles above 9 pass through unchanged; `seg_decode` blanks them.
- `frame_o` pulses on every frame boundary, including the entry from IDLE.

## Timing
- All outputs are registered; `sel_o` and `data_o` change on the same edge.
- Reset values:
  - FSM = IDLE, `cnt`=0, `idx`=0.
  - shadow, active = 0; pending = 0.
  - `data_o`=4'hF; `sel_o` all inactive (all ones if SEL_INVERSE, else zeros).
  - `frame_o`=0, `load_done_o`=0.
- `en_i` sampled high at edge N → digit 0 is selected from edge N+1; `frame_o` is high for the cycle after N+1.
- Slot length is exactly SCAN_DIV cycles: SCAN_DIV-BLANK_CYCLES cycles selected, BLANK_CYCLES cycles blank. Frame length = DIGITS*SCAN_DIV.
- `load_i` → displayed: at most one frame + 1 cycle after the next frame boundary; never mid-frame.
- Reset asserted mid-slot: all outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset/idle (DIGITS=4, SCAN_DIV=4, BLANK_CYCLES=1, SEL_INVERSE=1): `rst_n`=0 → `sel_o`=4'b1111, `data_o`=4'hF; `en_i`=0 for 20 cycles → outputs unchanged.
- Scan order: load 16'h4321, `en_i`=1 → per slot, 3 cycles selected then 1 blank. Sequence is (`sel_o`=1110, `data_o`=1), (1101, 2), (1011, 3), (0111, 4); `frame_o` pulses every 16 cycles.
- Tear-free load: load 16'h8765 during the digit-2 slot → rest of the frame still shows 3, 4. `load_done_o` pulses at the next digit-0 entry, then digits 5, 6, 7, 8.
- Simultaneous events: `load_i` at the frame-boundary edge with 16'h1111 while pending holds 16'h2222 → 2222 is displayed; pending stays 1; 1111 is displayed the following frame.
- Leading zeros (LZ_BLANK=1): active 16'h0050 → `data_o` sequence 0, 5, F, F. Active 16'h0000 → 0, F, F, F.
- Disable/reset mid-operation: `en_i`=0 during digit 2 → next edge `sel_o`=1111. Re-enable → restarts at digit 0 with `frame_o` pulse. Async `rst_n` low mid-slot → outputs at reset values before the next edge.
